// File: rtl/rcc_pkg.sv
// RCC divider-select control: shared types and constants.
// FSM encoding, canonical select codes and select canonicaliser.
package rcc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BND = 2'd1,
    SETTLE   = 2'd2
  } st_t;

  localparam logic [2:0] DIV_SEL_1  = 3'b000;
  localparam logic [2:0] DIV_SEL_2  = 3'b100;
  localparam logic [2:0] DIV_SEL_4  = 3'b101;
  localparam logic [2:0] DIV_SEL_8  = 3'b110;
  localparam logic [2:0] DIV_SEL_16 = 3'b111;

  // All 0xx encodings mean /1; fold them onto a single code.
  function automatic logic [2:0] canon_sel(input logic [2:0] s);
    return s[2] ? s : DIV_SEL_1;
  endfunction

endpackage

// File: rtl/rcc_div_sel_ctrl.sv
// Divider select control: applies prescaler changes on div_en
// boundaries, settles, then pulses upd_done; forces on timeout.
module rcc_div_sel_ctrl
  import rcc_pkg::*;
#(
  parameter logic [2:0]  RST_SEL    = 3'b000,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned TMO_CYC    = 32
) (
  input  logic       i_clk,
  input  logic       rst_n,
  input  logic [2:0] cfg_sel,
  input  logic       cfg_vld,
  output logic       cfg_rdy,
  input  logic       div_en,
  output logic [2:0] div_sel,
  output logic       upd_done,
  output logic       busy,
  output logic       tmo_err,
  input  logic       err_clr
);

  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  localparam logic [3:0]    SET_LAST = 4'(SETTLE_CYC - 1);

  st_t           st, st_n;
  logic [2:0]    pend, pend_n;
  logic [2:0]    sel_n;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic [3:0]    set_cnt, set_n;
  logic          done_n, err_n;
  logic [2:0]    req;

  assign req     = canon_sel(cfg_sel);
  assign cfg_rdy = (st == IDLE);
  assign busy    = (st != IDLE);

  always_comb begin
    st_n   = st;
    pend_n = pend;
    sel_n  = div_sel;
    tmo_n  = tmo_cnt;
    set_n  = set_cnt;
    done_n = 1'b0;
    err_n  = tmo_err;
    if (err_clr) err_n = 1'b0;
    unique case (st)
      IDLE: begin
        if (cfg_vld) begin
          pend_n = req;
          if (req == div_sel) begin
            done_n = 1'b1;
          end else begin
            st_n  = WAIT_BND;
            tmo_n = '0;
          end
        end
      end
      WAIT_BND: begin
        tmo_n = tmo_cnt + 1'b1;
        // A real boundary takes priority over the forced update.
        if (div_en) begin
          sel_n = pend;
          set_n = '0;
          st_n  = SETTLE;
        end else if (tmo_cnt == TMO_LAST) begin
          sel_n = pend;
          set_n = '0;
          err_n = 1'b1;
          st_n  = SETTLE;
        end
      end
      SETTLE: begin
        set_n = set_cnt + 1'b1;
        if (set_cnt == SET_LAST) begin
          done_n = 1'b1;
          st_n   = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      div_sel  <= RST_SEL;
      pend     <= RST_SEL;
      tmo_cnt  <= '0;
      set_cnt  <= '0;
      upd_done <= 1'b0;
      tmo_err  <= 1'b0;
    end else begin
      st       <= st_n;
      div_sel  <= sel_n;
      pend     <= pend_n;
      tmo_cnt  <= tmo_n;
      set_cnt  <= set_n;
      upd_done <= done_n;
      tmo_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_rcc_div_sel_ctrl.sv
// Directed bench for rcc_div_sel_ctrl.
// Scenario tasks run in sequence, each with inline checks.
module tb_rcc_div_sel_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] cfg_sel;
  logic       cfg_vld;
  logic       cfg_rdy;
  logic       div_en;
  logic [2:0] div_sel;
  logic       upd_done;
  logic       busy;
  logic       tmo_err;
  logic       err_clr;

  int pass_cnt = 0;
  int total    = 0;

  rcc_div_sel_ctrl #(
    .RST_SEL   (3'b000),
    .SETTLE_CYC(2),
    .TMO_CYC   (32)
  ) dut (
    .i_clk   (clk),
    .rst_n   (rst_n),
    .cfg_sel (cfg_sel),
    .cfg_vld (cfg_vld),
    .cfg_rdy (cfg_rdy),
    .div_en  (div_en),
    .div_sel (div_sel),
    .upd_done(upd_done),
    .busy    (busy),
    .tmo_err (tmo_err),
    .err_clr (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_sel = 3'b000; cfg_vld = 1'b0;
    div_en = 1'b0; err_clr = 1'b0;
    tick(); tick();
    total++;
    if (div_sel !== 3'b000) $display("FAIL rst_sel got=%b exp=000", div_sel);
    else pass_cnt++;
    total++;
    if (cfg_rdy !== 1'b1) $display("FAIL rst_rdy got=%b exp=1", cfg_rdy);
    else pass_cnt++;
    total++;
    if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy);
    else pass_cnt++;
    total++;
    if (upd_done !== 1'b0) $display("FAIL rst_done got=%b exp=0", upd_done);
    else pass_cnt++;
    total++;
    if (tmo_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", tmo_err);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_noop();
    cfg_sel = 3'b011; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    total++;
    if (upd_done !== 1'b1) $display("FAIL noop_done got=%b exp=1", upd_done);
    else pass_cnt++;
    total++;
    if (busy !== 1'b0) $display("FAIL noop_busy got=%b exp=0", busy);
    else pass_cnt++;
    total++;
    if (div_sel !== 3'b000) $display("FAIL noop_sel got=%b exp=000", div_sel);
    else pass_cnt++;
    tick();
    total++;
    if (upd_done !== 1'b0) $display("FAIL noop_pulse got=%b exp=0", upd_done);
    else pass_cnt++;
  endtask

  task automatic test_change();
    cfg_sel = 3'b101; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    total++;
    if (busy !== 1'b1 || cfg_rdy !== 1'b0)
      $display("FAIL chg_acc busy=%b rdy=%b exp busy=1 rdy=0", busy, cfg_rdy);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (div_sel !== 3'b000) $display("FAIL chg_wait got=%b exp=000", div_sel);
    else pass_cnt++;
    div_en = 1'b1;
    tick();
    div_en = 1'b0;
    total++;
    if (div_sel !== 3'b101) $display("FAIL chg_sel got=%b exp=101", div_sel);
    else pass_cnt++;
    tick();
    total++;
    if (upd_done !== 1'b0 || busy !== 1'b1)
      $display("FAIL chg_settle done=%b busy=%b exp done=0 busy=1", upd_done, busy);
    else pass_cnt++;
    tick();
    total++;
    if (upd_done !== 1'b1 || cfg_rdy !== 1'b1)
      $display("FAIL chg_done done=%b rdy=%b exp done=1 rdy=1", upd_done, cfg_rdy);
    else pass_cnt++;
  endtask

  // Starts in the upd_done cycle left by test_change.
  task automatic test_back_to_back_timeout();
    cfg_sel = 3'b111; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL b2b_acc got=%b exp=1", busy);
    else pass_cnt++;
    for (int i = 0; i < 31; i++) tick();
    total++;
    if (div_sel !== 3'b101 || tmo_err !== 1'b0)
      $display("FAIL tmo_early sel=%b err=%b exp sel=101 err=0", div_sel, tmo_err);
    else pass_cnt++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (div_sel !== 3'b111) $display("FAIL tmo_sel got=%b exp=111", div_sel);
    else pass_cnt++;
    total++;
    if (tmo_err !== 1'b1) $display("FAIL tmo_set got=%b exp=1", tmo_err);
    else pass_cnt++;
    tick(); tick();
    total++;
    if (upd_done !== 1'b1) $display("FAIL tmo_done got=%b exp=1", upd_done);
    else pass_cnt++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (tmo_err !== 1'b0) $display("FAIL err_clr got=%b exp=0", tmo_err);
    else pass_cnt++;
  endtask

  task automatic test_coincide();
    cfg_sel = 3'b100; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    div_en = 1'b1;
    tick();
    div_en = 1'b0;
    total++;
    if (div_sel !== 3'b100) $display("FAIL coin_sel got=%b exp=100", div_sel);
    else pass_cnt++;
    total++;
    if (tmo_err !== 1'b0) $display("FAIL coin_err got=%b exp=0", tmo_err);
    else pass_cnt++;
    tick(); tick();
    total++;
    if (upd_done !== 1'b1) $display("FAIL coin_done got=%b exp=1", upd_done);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    cfg_sel = 3'b110; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    div_en = 1'b1;
    tick();
    div_en = 1'b0;
    total++;
    if (div_sel !== 3'b110) $display("FAIL mid_sel got=%b exp=110", div_sel);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (div_sel !== 3'b000) $display("FAIL mid_async got=%b exp=000", div_sel);
    else pass_cnt++;
    total++;
    if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy);
    else pass_cnt++;
    tick(); tick();
    total++;
    if (upd_done !== 1'b0) $display("FAIL mid_done got=%b exp=0", upd_done);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total++;
    if (cfg_rdy !== 1'b1 || upd_done !== 1'b0)
      $display("FAIL mid_rel rdy=%b done=%b exp rdy=1 done=0", cfg_rdy, upd_done);
    else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_noop();
    test_change();
    test_back_to_back_timeout();
    test_coincide();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
